// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lock_pkg
//  Purpose  : Shared display constants and the 4-bit code to active-low
//             seven-segment glyph function used by the lock display paths.
//  Revision : 1.0 - initial release
// ============================================================================
package lock_pkg;

    localparam int          NUM_DIGITS  = 6;

    // Special display codes produced by the lock controller
    localparam logic [3:0]  GLYPH_E     = 4'hE;
    localparam logic [3:0]  GLYPH_BLANK = 4'hF;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0]  SEG_OFF     = 7'h7F;
    localparam logic [6:0]  SEG_DASH    = 7'h3F;
    localparam logic [6:0]  SEG_E       = 7'h06;

    // Codes 0..9 are decimal glyphs, A..D render as a dash, E as the letter E,
    // and F (plus anything unexpected) is blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        logic [6:0] pat;
        pat = SEG_OFF;
        case (code)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA,
            4'hB,
            4'hC,
            4'hD:    pat = SEG_DASH;
            GLYPH_E: pat = SEG_E;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage : lock_pkg
`default_nettype wire

// File: rtl/seg_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg_decoder
//  Purpose  : Combinational 4-bit display code to active-low segment pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_decoder
    import lock_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    assign seg_o = bcd_to_seg(code_i);

endmodule : seg_decoder
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_driver
//  Purpose  : Six-digit multiplexed seven-segment driver with frame-coherent
//             digit shadowing, an anti-ghosting dark cycle per slot and an
//             alarm-driven blink of the whole display.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import lock_pkg::*;
#(
    parameter int DIV         = 50000,
    parameter int BLINK_TICKS = 100
)
(
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    input  logic [3:0] d5,
    input  logic [3:0] d6,
    input  logic       alarm,
    output logic [6:0] seg,
    output logic [5:0] an
);

    localparam int             CW       = $clog2(DIV);
    localparam int             BW       = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DIV - 1);
    localparam logic [BW-1:0]  BCNT_MAX = BW'(BLINK_TICKS - 1);
    localparam logic [2:0]     IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [CW-1:0]       cnt_q,  cnt_d;
    logic [2:0]          idx_q,  idx_d;
    logic [5:0][3:0]     sh_q,   sh_d;
    logic                init_q;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic                bph_q,  bph_d;
    logic [5:0]          an_q,   an_d;
    logic [6:0]          seg_q,  seg_d;

    logic                tick;
    logic                frame_wrap;
    logic [3:0]          cur_digit;
    logic [6:0]          cur_glyph;

    assign tick       = (cnt_q == CNT_MAX);
    assign frame_wrap = tick && (idx_q == IDX_LAST);
    assign cur_digit  = sh_q[idx_q];

    seg_decoder u_decoder (
        .code_i (cur_digit),
        .seg_o  (cur_glyph)
    );

    // Next-state for prescaler, slot index, shadows, blink and output registers
    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + CW'(1);
        idx_d  = idx_q;
        sh_d   = sh_q;
        bcnt_d = bcnt_q;
        bph_d  = bph_q;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end

        // Shadows change only at frame boundaries so a frame is never torn
        if (init_q || frame_wrap) begin
            sh_d = {d6, d5, d4, d3, d2, d1};
        end

        if (!alarm) begin
            bcnt_d = '0;
            bph_d  = 1'b0;
        end else if (tick) begin
            if (bcnt_q == BCNT_MAX) begin
                bcnt_d = '0;
                bph_d  = ~bph_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end

        // Dark on the first cycle of each slot and during the blink-off phase
        if ((cnt_q == '0) || (alarm && bph_q)) begin
            an_d = '1;
        end else begin
            an_d = ~(6'b000001 << idx_q);
        end
        seg_d = cur_glyph;
    end

    // State and output registers, asynchronously cleared to a dark display
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            sh_q   <= {NUM_DIGITS{GLYPH_BLANK}};
            init_q <= 1'b1;
            bcnt_q <= '0;
            bph_q  <= 1'b0;
            an_q   <= '1;
            seg_q  <= SEG_OFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            sh_q   <= sh_d;
            init_q <= 1'b0;
            bcnt_q <= bcnt_d;
            bph_q  <= bph_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule : seg_scan_driver
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_driver
//  Purpose  : Directed scoreboard bench for seg_scan_driver (DIV=4,
//             BLINK_TICKS=2): startup, frame snapshot, glyphs, blink,
//             mid-frame clear and steady multi-frame scanning.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int DIV         = 4;
    localparam int BLINK_TICKS = 2;

    // Active-low {g,f,e,d,c,b,a} reference glyphs
    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78;
    localparam logic [6:0] S8 = 7'h00, S9 = 7'h10, SD = 7'h3F, SE = 7'h06;
    localparam logic [6:0] SB = 7'h7F;
    localparam logic [5:0] AN_OFF = 6'h3F;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
    } exp_t;

    logic       clk;
    logic       clr;
    logic [3:0] d1, d2, d3, d4, d5, d6;
    logic       alarm;
    logic [6:0] seg;
    logic [5:0] an;

    exp_t  sb_q[$];
    int    checks;
    int    errors;
    string tag;
    logic  count_en;
    int    slot_cnt [6];

    seg_scan_driver #(
        .DIV         (DIV),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .d4    (d4),
        .d5    (d5),
        .d6    (d6),
        .alarm (alarm),
        .seg   (seg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [5:0] a, input logic [6:0] s);
        exp_t e;
        e.an  = a;
        e.seg = s;
        sb_q.push_back(e);
    endtask

    // One slot: a dark guard cycle followed by three enabled cycles
    task automatic push_slot(input int k, input logic [6:0] g, input logic dark);
        logic [5:0] a;
        a = dark ? AN_OFF : ~(6'b000001 << k);
        push_exp(AN_OFF, g);
        repeat (3) push_exp(a, g);
    endtask

    task automatic push_frame(input logic [5:0][6:0] g);
        for (int k = 0; k < 6; k++) push_slot(k, g[k], 1'b0);
    endtask

    // First frame after clear: guard cycle still shows the blank reset shadow
    task automatic push_startup(input logic [5:0][6:0] g);
        push_exp(AN_OFF, SB);
        repeat (3) push_exp(6'h3E, g[0]);
        for (int k = 1; k < 6; k++) push_slot(k, g[k], 1'b0);
    endtask

    task automatic run_queue();
        exp_t e;
        while (sb_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            checks++;
            assert (an === e.an && seg === e.seg) else begin
                errors++;
                $error("FAIL %s: got an=%b seg=%b, expected an=%b seg=%b",
                       tag, an, seg, e.an, e.seg);
            end
            checks++;
            assert ($countones(~an) <= 1) else begin
                errors++;
                $error("FAIL %s onehot: got an=%b, expected at most one low bit", tag, an);
            end
            if (count_en) begin
                for (int k = 0; k < 6; k++) begin
                    if (an == ~(6'b000001 << k)) slot_cnt[k]++;
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        count_en = 1'b0;
        for (int k = 0; k < 6; k++) slot_cnt[k] = 0;
        clr   = 1'b1;
        alarm = 1'b0;
        d1 = 4'd1; d2 = 4'd2; d3 = 4'd3; d4 = 4'd4; d5 = 4'd5; d6 = 4'd6;

        // Reset state
        tag = "reset";
        repeat (2) @(posedge clk);
        #1;
        checks++;
        assert (an === AN_OFF) else begin
            errors++;
            $error("FAIL reset_an: got %b, expected %b", an, AN_OFF);
        end
        checks++;
        assert (seg === SB) else begin
            errors++;
            $error("FAIL reset_seg: got %b, expected %b", seg, SB);
        end

        // Startup frame after release
        clr = 1'b0;
        tag = "startup";
        push_startup({S6, S5, S4, S3, S2, S1});
        run_queue();

        // Frame snapshot: change d1/d3 while slot 2 is being entered
        tag = "snapshot";
        push_slot(0, S1, 1'b0);
        push_slot(1, S2, 1'b0);
        run_queue();
        d1 = 4'd7;
        d3 = 4'd8;
        push_slot(2, S3, 1'b0);
        push_slot(3, S4, 1'b0);
        push_slot(4, S5, 1'b0);
        push_slot(5, S6, 1'b0);
        run_queue();

        // New frame picks up 7 and 8; glyph codes set now appear next frame
        d3 = 4'hE;
        d4 = 4'hF;
        d5 = 4'hB;
        push_frame({S6, S5, S4, S8, S2, S7});
        run_queue();

        tag = "glyphs";
        push_frame({S6, SD, SB, SE, S2, S7});
        run_queue();

        // Blink: two normal ticks, two dark ticks, then scanning again
        tag = "blink";
        alarm = 1'b1;
        push_slot(0, S7, 1'b0);
        push_slot(1, S2, 1'b0);
        push_slot(2, SE, 1'b1);
        push_slot(3, SB, 1'b1);
        push_slot(4, SD, 1'b0);
        push_slot(5, S6, 1'b0);
        run_queue();

        // Next dark phase starts at slot 0; drop alarm part-way through it
        tag = "alarm_off";
        push_exp(AN_OFF, S7);
        push_exp(AN_OFF, S7);
        run_queue();
        alarm = 1'b0;
        push_exp(6'h3E, S7);
        push_exp(6'h3E, S7);
        push_slot(1, S2, 1'b0);
        push_slot(2, SE, 1'b0);
        push_slot(3, SB, 1'b0);
        push_slot(4, SD, 1'b0);
        push_slot(5, S6, 1'b0);
        run_queue();

        // Clear asserted during slot 3
        tag = "midclear";
        push_slot(0, S7, 1'b0);
        push_slot(1, S2, 1'b0);
        push_slot(2, SE, 1'b0);
        push_exp(AN_OFF, SB);
        push_exp(6'h37, SB);
        run_queue();
        clr = 1'b1;
        #1;
        checks++;
        assert (an === AN_OFF) else begin
            errors++;
            $error("FAIL midclear_an: got %b, expected %b", an, AN_OFF);
        end
        checks++;
        assert (seg === SB) else begin
            errors++;
            $error("FAIL midclear_seg: got %b, expected %b", seg, SB);
        end
        d1 = 4'd9; d2 = 4'd0; d3 = 4'd6; d4 = 4'd3; d5 = 4'hA; d6 = 4'd8;
        @(posedge clk);
        #1;
        clr = 1'b0;
        tag = "restart";
        push_startup({S8, SD, S3, S6, S0, S9});
        run_queue();

        // Three steady frames with per-slot enable counting
        tag = "wrap";
        count_en = 1'b1;
        repeat (3) push_frame({S8, SD, S3, S6, S0, S9});
        run_queue();
        count_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            assert (slot_cnt[k] == 9) else begin
                errors++;
                $error("FAIL wrap_slot%0d_count: got %0d, expected 9", k, slot_cnt[k]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seg_scan_driver
`default_nettype wire
